// File: rtl/aes_rx_loader.sv
`timescale 1ns/1ps
// aes_rx_loader: assembles a 32-byte UART frame (16 plaintext + 16 key bytes)
// into the AES core operands, pulses start, then waits for the core's done
// level to rise before accepting the next frame. Flags a stalled partial frame
// (timeout) and bytes arriving while the core is busy (overrun).
module aes_rx_loader #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_rx_valid,
  input  logic [7:0]   i_rx_byte,
  input  logic         i_aes_done,
  output logic [0:127] o_plain,
  output logic [0:127] o_key,
  output logic         o_start,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_timeout,
  output logic         o_overrun
);

  localparam int            TW     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = '1;

  typedef enum logic [1:0] {IDLE, COLLECT, START, WAIT_DONE} state_e;

  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [0:127]  plain_q, key_q;
  logic          done_prev_q;
  logic          done_pulse_q, done_pulse_d;
  logic          timeout_q, overrun_q;
  logic          store_en, set_timeout, set_overrun;
  logic [4:0]    wr_idx;

  // State, byte counter, inter-byte timer and done-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tmr_q        <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  // Next-state logic; a byte beats a simultaneous timer expiry.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    done_pulse_d = 1'b0;
    store_en     = 1'b0;
    set_timeout  = 1'b0;
    set_overrun  = 1'b0;
    wr_idx       = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          store_en = 1'b1;
          wr_idx   = 5'd0;
          cnt_d    = 5'd1;
          tmr_d    = '0;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (i_rx_valid) begin
          store_en = 1'b1;
          cnt_d    = cnt_q + 5'd1;   // wraps to 0 after byte 31
          tmr_d    = '0;
          if (cnt_q == 5'd31) state_d = START;
        end else if (tmr_q == T_LAST) begin
          set_timeout = 1'b1;
          cnt_d       = '0;
          tmr_d       = '0;
          state_d     = IDLE;
        end else if (tmr_q != T_MAX) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      START: begin
        if (i_rx_valid) set_overrun = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_rx_valid) set_overrun = 1'b1;
        // Only a fresh 0->1 transition counts; a level left high is ignored.
        if (i_aes_done && !done_prev_q) begin
          done_pulse_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture: first received byte lands in the MSB of each operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plain_q <= '0;
      key_q   <= '0;
    end else if (store_en) begin
      if (wr_idx[4]) key_q[{wr_idx[3:0], 3'b000} +: 8]   <= i_rx_byte;
      else           plain_q[{wr_idx[3:0], 3'b000} +: 8] <= i_rx_byte;
    end
  end

  // Done history is tracked every cycle so a stale high level never looks like a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_prev_q <= 1'b0;
    else        done_prev_q <= i_aes_done;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (set_timeout) timeout_q <= 1'b1;
      if (set_overrun) overrun_q <= 1'b1;
    end
  end

  assign o_plain   = plain_q;
  assign o_key     = key_q;
  assign o_start   = (state_q == START);
  assign o_busy    = (state_q != IDLE);
  assign o_done    = done_pulse_q;
  assign o_timeout = timeout_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_aes_rx_loader.sv
`timescale 1ns/1ps
// Directed + randomized bench for aes_rx_loader. The reference model is a
// 32-entry byte array indexed by frame position; expected operands are the
// bytes concatenated in arrival order.
module tb_aes_rx_loader;
  localparam int TO = 16;

  logic         clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, aes_done = 1'b0;
  logic [7:0]   rx_byte = '0;
  logic [0:127] plain, key;
  logic         start, busy, done, tmo, ovr;

  int passed = 0, total = 0;
  int start_cnt = 0, done_cnt = 0;
  logic [7:0] mdl [32];
  logic [7:0] kv  [32] = '{8'h32,8'h43,8'hf6,8'ha8,8'h88,8'h5a,8'h30,8'h8d,
                           8'h31,8'h31,8'h98,8'ha2,8'he0,8'h37,8'h07,8'h34,
                           8'h2b,8'h7e,8'h15,8'h16,8'h28,8'hae,8'hd2,8'ha6,
                           8'hab,8'hf7,8'h15,8'h88,8'h09,8'hcf,8'h4f,8'h3c};
  localparam logic [255:0] KV_VEC =
    256'h3243f6a8885a308d313198a2e0370734_2b7e151628aed2a6abf7158809cf4f3c;

  aes_rx_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .i_aes_done(aes_done), .o_plain(plain), .o_key(key), .o_start(start),
    .o_busy(busy), .o_done(done), .o_timeout(tmo), .o_overrun(ovr));

  always #5 clk = ~clk;

  // Pulse counters observed on the active edge.
  always @(posedge clk) begin
    if (start) start_cnt++;
    if (done)  done_cnt++;
  end

  function automatic logic [255:0] mdl_vec();
    logic [255:0] v = '0;
    for (int i = 0; i < 32; i++) v = {v[247:0], mdl[i]};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Called at a negedge; byte is sampled on the following posedge.
  task automatic send(input logic [7:0] b, input int idx);
    rx_valid = 1'b1;
    rx_byte  = b;
    mdl[idx] = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic finish_op(input string tag);
    int d0;
    d0 = done_cnt;
    aes_done = 1'b0;
    idle(2);
    aes_done = 1'b1;
    @(negedge clk);
    chk({tag, "_done_hi"}, {done, busy}, 2'b10);
    @(negedge clk);
    chk({tag, "_done_lo"}, done, 0);
    chk({tag, "_done_once"}, done_cnt - d0, 1);
  endtask

  initial begin
    int s0;
    foreach (mdl[i]) mdl[i] = '0;
    aes_done = 1'b1;               // stale done level from an earlier operation
    idle(2);
    chk("rst_data",  {plain, key}, '0);
    chk("rst_flags", {start, busy, done, tmo, ovr}, '0);
    rst_n = 1'b1;
    idle(1);

    // Known-answer frame, back-to-back bytes.
    s0 = start_cnt;
    for (int i = 0; i < 32; i++) send(kv[i], i);
    chk("kat_start", {start, busy}, 2'b11);
    chk("kat_data",  {plain, key}, KV_VEC);
    idle(1);
    chk("kat_start_lo",  start, 0);
    chk("kat_start_cnt", start_cnt - s0, 1);

    // Done held high from before must not complete the operation.
    idle(6);
    chk("stale_done_busy", busy, 1);
    chk("stale_done_cnt",  done_cnt, 0);

    // Byte during WAIT_DONE is dropped.
    rx_valid = 1'b1; rx_byte = 8'hAA;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("ovr_flag", {ovr, busy}, 2'b11);
    chk("ovr_data", {plain, key}, mdl_vec());
    finish_op("op1");

    // Random frame; byte 3 lands exactly in the timer-expiry cycle.
    s0 = start_cnt;
    for (int i = 0; i < 32; i++) begin
      if (i == 3) begin
        idle(TO - 1);
        chk("pre_expiry", {busy, tmo}, 2'b10);
      end else if (i > 0) idle(int'($urandom_range(0, 4)));
      send(8'($urandom), i);
      if (i == 3) chk("expiry_byte_wins", {busy, tmo}, 2'b10);
    end
    chk("rnd1_start", start, 1);
    chk("rnd1_data",  {plain, key}, mdl_vec());
    finish_op("op2");

    // Partial frame of 5 bytes then stall.
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) send(8'($urandom), i);
    idle(TO - 1);
    chk("tmo_not_yet", {busy, tmo}, 2'b10);
    idle(1);
    chk("tmo_flag",    {busy, tmo}, 2'b01);
    chk("tmo_partial", {plain, key}, mdl_vec());
    idle(3);
    chk("tmo_no_start", start_cnt - s0, 0);

    // Following frame starts normally.
    for (int i = 0; i < 32; i++) begin
      if (i > 0) idle(int'($urandom_range(0, 6)));
      send(8'($urandom), i);
    end
    chk("rnd2_start", start, 1);
    chk("rnd2_data",  {plain, key}, mdl_vec());
    idle(1);
    chk("rnd2_start_cnt", start_cnt - s0, 1);
    finish_op("op3");
    chk("tmo_sticky", {tmo, ovr}, 2'b11);

    // Reset after 20 bytes discards everything.
    s0 = start_cnt;
    for (int i = 0; i < 20; i++) send(8'($urandom), i);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data",  {plain, key}, '0);
    chk("mid_rst_flags", {start, busy, done, tmo, ovr}, '0);
    foreach (mdl[i]) mdl[i] = '0;
    idle(2);
    chk("mid_rst_hold", {start, busy, done, tmo, ovr}, '0);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 32; i++) send(kv[i], i);
    chk("post_rst_start", start, 1);
    chk("post_rst_data",  {plain, key}, KV_VEC);
    idle(1);
    chk("post_rst_start_cnt", start_cnt - s0, 1);
    finish_op("op4");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/aes_rx_loader.md
AES_RX_LOADER -- requirements
Module: aes_rx_loader

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, the maximum number of idle clk cycles allowed between consecutive bytes of one frame.
REQ-002 The block SHALL have the port clk, input, 1 bit, system clock (100 MHz), all logic rising-edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit, reset, asynchronous assert, active-low.
REQ-004 The block SHALL have the port i_rx_valid, input, 1 bit, single-cycle strobe marking a received UART byte.
REQ-005 The block SHALL have the port i_rx_byte, input, 8 bits, received byte, meaningful only when i_rx_valid=1.
REQ-006 The block SHALL have the port i_aes_done, input, 1 bit, level done flag from the AES core.
REQ-007 The block SHALL have the port o_plain, output, 128 bits [0:127], plaintext to the AES core.
REQ-008 The block SHALL have the port o_key, output, 128 bits [0:127], key to the AES core.
REQ-009 The block SHALL have the port o_start, output, 1 bit, single-cycle start pulse to the AES core.
REQ-010 The block SHALL have the port o_busy, output, 1 bit, high in any state other than IDLE.
REQ-011 The block SHALL have the port o_done, output, 1 bit, single-cycle pulse when the AES operation completes.
REQ-012 The block SHALL have the port o_timeout, output, 1 bit, sticky flag set when a partial frame is dropped.
REQ-013 The block SHALL have the port o_overrun, output, 1 bit, sticky flag set when a byte arrives in START or WAIT_DONE.

Function
REQ-014 A frame SHALL be 32 bytes: bytes 0-15 form the plaintext, bytes 16-31 form the key.
REQ-015 Byte n (n<16) SHALL be written to o_plain[8n:8n+7], and byte n (n>=16) to o_key[8(n-16):8(n-16)+7], so the first byte is the MSB.
REQ-016 The FSM SHALL have the states IDLE, COLLECT, START and WAIT_DONE.
REQ-017 In IDLE, an i_rx_valid SHALL store byte 0, set the 5-bit byte counter to 1, and move the FSM to COLLECT.
REQ-018 In COLLECT, each i_rx_valid SHALL store the byte at the counter index and increment the counter.
REQ-019 When byte 31 is stored, the FSM SHALL move to START on the next edge, and the counter SHALL wrap to 0.
REQ-020 START SHALL last exactly one cycle with o_start=1, so o_start is high in the cycle after byte 31 is captured; the FSM then moves to WAIT_DONE.
REQ-021 o_plain and o_key SHALL stay stable from START until the FSM next leaves IDLE.
REQ-022 WAIT_DONE SHALL register i_aes_done, and on a rising edge (previous 0, current 1) it SHALL pulse o_done for one cycle and return to IDLE.
REQ-023 A done level left high from a previous operation SHALL NOT complete WAIT_DONE; the FSM SHALL wait until done falls and rises again.
REQ-024 The inter-byte timer SHALL reset on every accepted byte and count only in COLLECT.
REQ-025 When the timer reaches TIMEOUT_CYCLES-1 without a byte arriving, the block SHALL set o_timeout, clear the counter, and return to IDLE; o_plain and o_key SHALL keep their partial contents but SHALL NOT be started.
REQ-026 If a byte arrives in the same cycle the timer expires, the byte SHALL win: it is accepted and the timer is reset.
REQ-027 An i_rx_valid in START or WAIT_DONE SHALL drop the byte, set o_overrun, and leave the FSM and data unchanged.
REQ-028 o_timeout and o_overrun SHALL clear only on reset.
REQ-029 The timer width SHALL be $clog2(TIMEOUT_CYCLES)+1 bits, and the timer SHALL NOT wrap.

Reset
REQ-030 Asserting rst_n=0 SHALL force, immediately and asynchronously: FSM=IDLE, counter=0, timer=0, o_plain=0, o_key=0, o_start=0, o_busy=0, o_done=0, o_timeout=0, o_overrun=0.
REQ-031 A reset in the middle of a frame or in WAIT_DONE SHALL discard all progress; the first byte after release SHALL be treated as byte 0.

Verification
REQ-032 The bench SHALL send 32 bytes, plaintext 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34 then key 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c; it SHALL check o_plain=3243f6a8885a308d313198a2e0370734, o_key=2b7e151628aed2a6abf7158809cf4f3c, and a single o_start pulse one cycle after the last byte.
REQ-033 In WAIT_DONE, the bench SHALL hold i_aes_done=1, then take it to 0, then to 1; o_done SHALL pulse exactly once, one cycle after the rise, with o_busy=0 afterwards.
REQ-034 With TIMEOUT_CYCLES=16, the bench SHALL send 5 bytes then idle 16 cycles; it SHALL check o_timeout=1, FSM=IDLE, and o_start never asserted, and a following full frame SHALL start normally.
REQ-035 The bench SHALL send a byte during WAIT_DONE and check o_overrun=1, with o_plain and o_key unchanged.
REQ-036 The bench SHALL assert rst_n=0 after 20 bytes and then send a full 32-byte frame; it SHALL check that all outputs were 0 during reset and that the new frame loads correctly.
REQ-037 The bench SHALL deliver a byte in the exact timer-expiry cycle and check that the byte is accepted with no timeout.
